// File: rtl/ocp_arbiter2.sv
// rtl/ocp_arbiter2.sv - two-master OCP arbiter sharing one OCP slave
//
// Purpose: arbitrates between an instruction-fetch master (M0) and a data
// master (M1). It accepts one command at a time and registers it. It then
// replays the command to the slave until the slave accepts it. Read responses
// are routed back to the granted master. Only one transaction is outstanding
// at any time.
//
// Compile-time option: OCP_ARB_FIXED_PRIO_EN
//   defined   - M0 always wins contention
//   undefined - round-robin between M0 and M1 (default)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_MxAddr/Cmd/Data/ByteEn   master x command inputs (x = 0, 1)
//   o_SxCmdAccept       command accepted for master x
//   o_SxData/Resp       read data / response returned to master x
//   o_MAddr/MCmd/MData/MByteEn command replayed to the slave
//   i_SCmdAccept        slave accepts the replayed command
//   i_SData/SResp       slave read data / response

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif

module ocp_arbiter2 (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [`ADDR_WIDTH-1:0] i_M0Addr,
   input  logic [2:0]             i_M0Cmd,
   input  logic [`DATA_WIDTH-1:0] i_M0Data,
   input  logic [`BEN_WIDTH-1:0]  i_M0ByteEn,
   input  logic [`ADDR_WIDTH-1:0] i_M1Addr,
   input  logic [2:0]             i_M1Cmd,
   input  logic [`DATA_WIDTH-1:0] i_M1Data,
   input  logic [`BEN_WIDTH-1:0]  i_M1ByteEn,
   output logic                   o_S0CmdAccept,
   output logic [`DATA_WIDTH-1:0] o_S0Data,
   output logic [1:0]             o_S0Resp,
   output logic                   o_S1CmdAccept,
   output logic [`DATA_WIDTH-1:0] o_S1Data,
   output logic [1:0]             o_S1Resp,
   output logic [`ADDR_WIDTH-1:0] o_MAddr,
   output logic [2:0]             o_MCmd,
   output logic [`DATA_WIDTH-1:0] o_MData,
   output logic [`BEN_WIDTH-1:0]  o_MByteEn,
   input  logic                   i_SCmdAccept,
   input  logic [`DATA_WIDTH-1:0] i_SData,
   input  logic [1:0]             i_SResp
);

   localparam logic [2:0] CMD_IDLE  = 3'd0;
   localparam logic [2:0] CMD_WRITE = 3'd1;
   localparam logic [2:0] CMD_READ  = 3'd2;
   localparam logic [1:0] RESP_NULL = 2'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic                   gp;        // granted port: 0 = M0, 1 = M1
   logic [`ADDR_WIDTH-1:0] lat_addr;
   logic [2:0]             lat_cmd;
   logic [`DATA_WIDTH-1:0] lat_data;
   logic [`BEN_WIDTH-1:0]  lat_ben;
   logic                   req0;
   logic                   req1;
   logic                   win0;
   logic                   win1;
`ifndef OCP_ARB_FIXED_PRIO_EN
   logic                   lg;        // last granted port
`endif

   // Only READ and WRITE count as requests; any other non-idle code stalls.
   assign req0 = (i_M0Cmd == CMD_READ) || (i_M0Cmd == CMD_WRITE);
   assign req1 = (i_M1Cmd == CMD_READ) || (i_M1Cmd == CMD_WRITE);

   // Arbitration only in IDLE. It is gated by rst so that no accept leaks out
   // while reset is held.
   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
      if (state == ST_IDLE && !rst) begin
`ifdef OCP_ARB_FIXED_PRIO_EN
         win0 = req0;
         win1 = req1 && !req0;
`else
         if (req0 && req1) begin
            win0 = lg;
            win1 = !lg;
         end else begin
            win0 = req0;
            win1 = req1;
         end
`endif
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (win0 || win1) begin
               state_nxt = ST_CMD;
            end
         end
         ST_CMD: begin
            if (i_SCmdAccept) begin
               // Writes are posted: no response phase.
               state_nxt = (lat_cmd == CMD_READ) ? ST_RESP : ST_IDLE;
            end
         end
         ST_RESP: begin
            if (i_SResp != RESP_NULL) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Command latch and grant bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gp       <= 1'b0;
         lat_addr <= '0;
         lat_cmd  <= CMD_IDLE;
         lat_data <= '0;
         lat_ben  <= '0;
`ifndef OCP_ARB_FIXED_PRIO_EN
         lg       <= 1'b1;             // M0 wins the first contention
`endif
      end else if (win0 || win1) begin
         gp       <= win1;
         lat_addr <= win1 ? i_M1Addr   : i_M0Addr;
         lat_cmd  <= win1 ? i_M1Cmd    : i_M0Cmd;
         lat_data <= win1 ? i_M1Data   : i_M0Data;
         lat_ben  <= win1 ? i_M1ByteEn : i_M0ByteEn;
`ifndef OCP_ARB_FIXED_PRIO_EN
         lg       <= win1;
`endif
      end
   end

   // Output logic
   always_comb begin
      o_S0CmdAccept = win0;
      o_S1CmdAccept = win1;
      o_S0Resp      = RESP_NULL;
      o_S1Resp      = RESP_NULL;
      o_S0Data      = '0;
      o_S1Data      = '0;
      o_MCmd        = CMD_IDLE;
      o_MAddr       = '0;
      o_MData       = '0;
      o_MByteEn     = '0;
      case (state)
         ST_CMD: begin
            o_MCmd    = lat_cmd;
            o_MAddr   = lat_addr;
            o_MData   = lat_data;
            o_MByteEn = lat_ben;
         end
         ST_RESP: begin
            // Response forwarding is combinational: no added latency.
            if (gp) begin
               o_S1Resp = i_SResp;
               o_S1Data = i_SData;
            end else begin
               o_S0Resp = i_SResp;
               o_S0Data = i_SData;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/ocp_arbiter2.md
# ocp_arbiter2

Two-master OCP arbiter sharing one OCP slave, typically the behavioral `memory`, between an instruction-fetch port (M0) and a data port (M1). It accepts a command from one master and registers it. It then replays the command to the slave until the slave accepts it. For reads it routes the slave response back to the granted master. Only one transaction is outstanding at a time. Round-robin arbitration by default; fixed priority is selectable at compile time.

## Interface
Parameters: none. Widths are taken from `ADDR_WIDTH`, `DATA_WIDTH` and `BEN_WIDTH` in `common.vh`. Command and response codes come from `ocp_const.vh`.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_M0Addr, i_M1Addr  in  ADDR_WIDTH  master address
- i_M0Cmd, i_M1Cmd  in  3  master command (IDLE/READ/WRITE)
- i_M0Data, i_M1Data  in  DATA_WIDTH  master write data
- i_M0ByteEn, i_M1ByteEn  in  BEN_WIDTH  master byte enables
- o_S0CmdAccept, o_S1CmdAccept  out  1  command accepted by arbiter
- o_S0Data, o_S1Data  out  DATA_WIDTH  read data to master
- o_S0Resp, o_S1Resp  out  2  response to master
- o_MAddr  out  ADDR_WIDTH  slave address
- o_MCmd  out  3  slave command
- o_MData  out  DATA_WIDTH  slave write data
- o_MByteEn  out  BEN_WIDTH  slave byte enables
- i_SCmdAccept  in  1  slave accepts command
- i_SData  in  DATA_WIDTH  slave read data
- i_SResp  in  2  slave response

## Operation
- State machine: IDLE, CMD, RESP. Registers: state, last-grant pointer `lg`, latched addr/cmd/data/ben, granted-port id `gp`.
- Request: a port requests when its MCmd is READ or WRITE. Other non-IDLE codes are never accepted; the master stalls.
- IDLE, arbitration:
  - One requester: grant it.
  - Both requesting: grant the port that is not `lg`.
  - The winner's o_SxCmdAccept is driven 1 combinationally in that cycle.
  - On the edge: latch the winner's command, set `gp` and `lg` to the winner, go to CMD.
- CMD:
  - o_MCmd/o_MAddr/o_MData/o_MByteEn are driven from the latched registers.
  - Stay in CMD while i_SCmdAccept=0.
  - On i_SCmdAccept=1: a READ goes to RESP; a WRITE goes to IDLE. Writes are posted and produce no response to the master.
- RESP:
  - o_MCmd=IDLE.
  - i_SResp and i_SData are forwarded combinationally to o_SResp/o_SData of port `gp`.
  - On i_SResp≠NULL, go to IDLE on that edge.
- Non-granted ports, and all ports outside their accept or response cycle: o_SxCmdAccept=0 and o_SxResp=NULL. o_SxData is 0 except during the forwarding cycle.
- Outside CMD: o_MCmd=IDLE, o_MAddr=0, o_MData=0, o_MByteEn=0.
- Master obligations:
  - Hold the command until accepted.
  - After an accepted READ, drive IDLE until the response arrives.
- Reset:
  - rst=1 forces IDLE and `lg`=1, so M0 wins first contention.
  - All outputs go to 0/IDLE/NULL immediately.
  - An in-flight transaction is dropped, including a slave response that arrives after reset; it is not forwarded.

## Timing
- Read, with master command in cycle N and the arbiter in IDLE:
  - Accept in N.
  - o_MCmd valid in N+1.
  - With zero-wait slave accept and a response in N+2: master sees SResp=DVA in N+2.
  - Arbiter is back in IDLE at N+3, which is the earliest next accept.
- Write: accept in N, o_MCmd in N+1, next accept earliest N+2.
- A request arriving while state≠IDLE waits. It is evaluated in the first IDLE cycle.
- Response forwarding adds no latency. Command path adds exactly 1 cycle.

## Configuration
- `OCP_ARB_FIXED_PRIO_EN`:
  - Defined: M0 always wins contention; `lg` is unused.
  - Undefined (default): round-robin as above.

## Test plan
- Reset: assert rst mid-CMD with o_MCmd=READ.
  - o_MCmd=IDLE and all accepts/resps 0/NULL in the same cycle.
  - After release, first contention goes to M0.
- Single master read:
  - M0 writes 0xdeadbeef to 0x0 with ben 0xf, then reads 0x0.
  - Required: o_S0Resp=DVA with o_S0Data=0xdeadbeef, exactly 2 cycles after o_S0CmdAccept.
- Byte-enable pass-through:
  - M1 writes 0xbeefdead to 0x0 with ben 0x3, then M1 reads 0x0.
  - Required: o_S1Data=0xdeaddead; M0 outputs stay NULL throughout.
- Contention round-robin: M0 and M1 both hold READ continuously from reset release.
  - Grants are M0, M1, M0, M1.
  - Each response appears only on the owning port.
- Slave stall: slave holds i_SCmdAccept=0 for 3 cycles.
  - o_MCmd and o_MAddr stay stable for 4 cycles.
  - The other master's request is not accepted meanwhile.
- Fixed priority, built with `OCP_ARB_FIXED_PRIO_EN`: both masters request continuously.
  - M0 is granted every time; M1 is granted only once M0 drops to IDLE.
